// File: rtl/min_pkg.sv
// Shared MIN framing constants, FSM state type and CRC-32 byte step.
// Used by both the receive and transmit framing paths.
package min_pkg;

  localparam logic [7:0]  SOF_BYTE   = 8'hAA;
  localparam logic [7:0]  STUFF_BYTE = 8'h55;
  localparam logic [7:0]  EOF_BYTE   = 8'h55;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_ID,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC,
    ST_EOF
  } min_state_e;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  b
  );
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/min_receive_fsm_if.sv
// Byte-in / frame-out bundle for the MIN receive decoder.
// master = byte source and frame consumer, slave = decoder.
interface min_receive_fsm_if #(
  parameter int MAX_PAYLOAD = 4,
  parameter int LEN_WIDTH   = 6
);

  logic                     i_en;
  logic                     i_valid;
  logic [7:0]               i_data;
  logic                     o_frame;
  logic [7:0]               o_id;
  logic [LEN_WIDTH-1:0]     o_len;
  logic [8*MAX_PAYLOAD-1:0] o_data;
  logic                     o_crc_err;
  logic                     o_frame_err;

  modport master (
    output i_en, i_valid, i_data,
    input  o_frame, o_id, o_len, o_data,
    input  o_crc_err, o_frame_err
  );

  modport slave (
    input  i_en, i_valid, i_data,
    output o_frame, o_id, o_len, o_data,
    output o_crc_err, o_frame_err
  );

endinterface

// File: rtl/min_crc32.sv
// Byte-wide reflected CRC-32 register.
// Clear wins over update; output is the raw (uncomplemented) register.
module min_crc32
  import min_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_upd,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] crc_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_q <= CRC_INIT;
    end else if (i_clr) begin
      crc_q <= CRC_INIT;
    end else if (i_upd) begin
      crc_q <= crc32_byte(crc_q, i_data);
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/min_receive_fsm.sv
// MIN receive framing decoder: SOF search, unstuffing, CRC-32 check,
// shadow payload buffer published only on a good frame.
module min_receive_fsm
  import min_pkg::*;
#(
  parameter int MAX_PAYLOAD = 4,
  parameter int LEN_WIDTH   = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  min_receive_fsm_if.slave bus
);

  min_state_e               state_q;
  logic [1:0]               aa_cnt_q;
  logic [1:0]               crc_cnt_q;
  logic [LEN_WIDTH-1:0]     idx_q;
  logic [LEN_WIDTH-1:0]     len_sh_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [7:0]               id_sh_q;
  logic [7:0]               id_q;
  logic [7:0]               pay_q [MAX_PAYLOAD];
  logic [8*MAX_PAYLOAD-1:0] data_q;
  logic [31:0]              rx_crc_q;
  logic                     frame_q;
  logic                     crc_err_q;
  logic                     frame_err_q;

  logic        take;
  logic        is_aa;
  logic        sof;
  logic        stuff;
  logic        crc_upd;
  logic [1:0]  aa_next;
  logic [31:0] crc_w;

  assign take    = bus.i_en & bus.i_valid;
  assign is_aa   = bus.i_data == SOF_BYTE;
  assign sof     = take & is_aa & (aa_cnt_q == 2'd2);
  assign stuff   = (state_q != ST_SEARCH) & (aa_cnt_q == 2'd2);
  assign aa_next = is_aa ? aa_cnt_q + 2'd1 : 2'd0;
  assign crc_upd = take & ~stuff &
                   (state_q inside {ST_ID, ST_LEN, ST_PAYLOAD});

  min_crc32 u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (sof),
    .i_upd  (crc_upd),
    .i_data (bus.i_data),
    .o_crc  (crc_w)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_SEARCH;
      aa_cnt_q    <= '0;
      crc_cnt_q   <= '0;
      idx_q       <= '0;
      len_sh_q    <= '0;
      len_q       <= '0;
      id_sh_q     <= '0;
      id_q        <= '0;
      data_q      <= '0;
      rx_crc_q    <= '0;
      frame_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < MAX_PAYLOAD; k++) pay_q[k] <= '0;
    end else begin
      frame_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (sof) begin
        // A third AA always restarts the frame, whatever the state.
        state_q  <= ST_ID;
        aa_cnt_q <= '0;
        idx_q    <= '0;
        for (int k = 0; k < MAX_PAYLOAD; k++) pay_q[k] <= '0;
      end else if (take && stuff) begin
        aa_cnt_q <= '0;
        if (bus.i_data != STUFF_BYTE) begin
          frame_err_q <= 1'b1;
          state_q     <= ST_SEARCH;
        end
      end else if (take) begin
        unique case (state_q)
          ST_SEARCH: aa_cnt_q <= aa_next;
          ST_ID: begin
            aa_cnt_q <= aa_next;
            id_sh_q  <= bus.i_data;
            state_q  <= ST_LEN;
          end
          ST_LEN: begin
            aa_cnt_q  <= aa_next;
            len_sh_q  <= LEN_WIDTH'(bus.i_data);
            crc_cnt_q <= '0;
            if (bus.i_data > 8'(MAX_PAYLOAD)) begin
              frame_err_q <= 1'b1;
              aa_cnt_q    <= '0;
              state_q     <= ST_SEARCH;
            end else if (bus.i_data == 8'd0) begin
              state_q <= ST_CRC;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            aa_cnt_q <= aa_next;
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
              if (idx_q == LEN_WIDTH'(k)) pay_q[k] <= bus.i_data;
            end
            idx_q <= idx_q + LEN_WIDTH'(1);
            if (idx_q + LEN_WIDTH'(1) == len_sh_q) state_q <= ST_CRC;
          end
          ST_CRC: begin
            aa_cnt_q  <= aa_next;
            rx_crc_q  <= {rx_crc_q[23:0], bus.i_data};
            crc_cnt_q <= crc_cnt_q + 2'd1;
            if (crc_cnt_q == 2'd3) state_q <= ST_EOF;
          end
          ST_EOF: begin
            aa_cnt_q <= '0;
            state_q  <= ST_SEARCH;
            if (bus.i_data != EOF_BYTE) begin
              frame_err_q <= 1'b1;
            end else if ((crc_w ^ CRC_XOROUT) == rx_crc_q) begin
              frame_q <= 1'b1;
              id_q    <= id_sh_q;
              len_q   <= len_sh_q;
              for (int k = 0; k < MAX_PAYLOAD; k++) begin
                data_q[8*(MAX_PAYLOAD-1-k) +: 8] <= pay_q[k];
              end
            end else begin
              crc_err_q <= 1'b1;
            end
          end
          default: state_q <= ST_SEARCH;
        endcase
      end
    end
  end

  assign bus.o_frame     = frame_q;
  assign bus.o_id        = id_q;
  assign bus.o_len       = len_q;
  assign bus.o_data      = data_q;
  assign bus.o_crc_err   = crc_err_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_min_receive_fsm.sv
// Directed bench for min_receive_fsm: frame table plus corner sequences.
// Frames are built and CRC-ed by the bench, with its own stuffing.
module tb_min_receive_fsm;

  localparam int MAXP = 4;
  localparam int LW   = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  min_receive_fsm_if #(.MAX_PAYLOAD(MAXP), .LEN_WIDTH(LW)) bus ();

  min_receive_fsm #(.MAX_PAYLOAD(MAXP), .LEN_WIDTH(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic        cclr;
  logic        cupd;
  logic [7:0]  cdat;
  logic [31:0] cval;

  min_crc32 ucrc (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (cclr),
    .i_upd  (cupd),
    .i_data (cdat),
    .o_crc  (cval)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_frame = 0;
  int n_cerr  = 0;
  int n_ferr  = 0;
  bit multi   = 1'b0;

  always @(negedge clk) begin
    if (bus.o_frame) n_frame++;
    if (bus.o_crc_err) n_cerr++;
    if (bus.o_frame_err) n_ferr++;
    if ($countones({bus.o_frame, bus.o_crc_err, bus.o_frame_err}) > 1)
      multi = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  // modes: 0 good, 1 CRC byte flipped, 2 bad EOF,
  // 3 stop after LEN, 4 payload sent unstuffed then stop
  typedef struct {
    logic [7:0]  id;
    logic [7:0]  len;
    logic [31:0] pay;
    int          mode;
    int          ef;
    int          ec;
    int          ee;
    logic [7:0]  eid;
    logic [5:0]  elen;
    logic [31:0] edat;
  } vec_t;

  logic [7:0] txq[$];
  int         scnt;
  bit         stuff_en;

  function automatic logic [31:0] mcrc(input logic [31:0] c,
                                       input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  function automatic void push_s(input logic [7:0] b);
    txq.push_back(b);
    if (stuff_en) begin
      scnt = (b == 8'hAA) ? scnt + 1 : 0;
      if (scnt == 2) begin
        txq.push_back(8'h55);
        scnt = 0;
      end
    end
  endfunction

  function automatic void build(input logic [7:0] id, input logic [7:0] len,
                                input logic [31:0] pay, input int mode);
    logic [31:0] c;
    logic [7:0]  b;
    txq.delete();
    scnt     = 0;
    stuff_en = 1'b1;
    repeat (3) txq.push_back(8'hAA);
    c = 32'hFFFFFFFF;
    push_s(id);
    c = mcrc(c, id);
    push_s(len);
    c = mcrc(c, len);
    if (mode == 3) return;
    if (mode == 4) stuff_en = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      b = pay[31-8*i -: 8];
      push_s(b);
      c = mcrc(c, b);
    end
    if (mode == 4) return;
    c = c ^ 32'hFFFFFFFF;
    if (mode == 1) c[23:16] = ~c[23:16];
    push_s(c[31:24]);
    push_s(c[23:16]);
    push_s(c[15:8]);
    push_s(c[7:0]);
    txq.push_back(mode == 2 ? 8'h00 : 8'h55);
  endfunction

  // gap_at inserts a dropped (i_en low) AA before that byte index
  task automatic send(input int gap_at, input int n);
    for (int i = 0; i < n && i < txq.size(); i++) begin
      if (i == gap_at) begin
        @(negedge clk);
        bus.i_en = 1'b0; bus.i_valid = 1'b1; bus.i_data = 8'hAA;
      end
      @(negedge clk);
      bus.i_en = 1'b1; bus.i_valid = 1'b1; bus.i_data = txq[i];
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_frame(input string nm, input int ef, input int ec,
                           input int ee, input int f0, input int c0,
                           input int e0, input logic [7:0] eid,
                           input logic [5:0] elen, input logic [31:0] edat);
    chk({nm, ".frame"}, 64'(n_frame - f0), 64'(ef));
    chk({nm, ".crc_err"}, 64'(n_cerr - c0), 64'(ec));
    chk({nm, ".frame_err"}, 64'(n_ferr - e0), 64'(ee));
    chk({nm, ".id"}, 64'(bus.o_id), 64'(eid));
    chk({nm, ".len"}, 64'(bus.o_len), 64'(elen));
    chk({nm, ".data"}, 64'(bus.o_data), 64'(edat));
  endtask

  vec_t  vt[10];
  string s;
  int    f0, c0, e0;

  initial begin
    vt[0] = '{8'h80, 8'd4, 32'h01020304, 0, 1, 0, 0, 8'h80, 6'd4, 32'h01020304};
    vt[1] = '{8'h11, 8'd2, 32'hA55A0000, 0, 1, 0, 0, 8'h11, 6'd2, 32'hA55A0000};
    vt[2] = '{8'h22, 8'd0, 32'h00000000, 0, 1, 0, 0, 8'h22, 6'd0, 32'h00000000};
    vt[3] = '{8'h33, 8'd3, 32'h01020300, 1, 0, 1, 0, 8'h22, 6'd0, 32'h00000000};
    vt[4] = '{8'h44, 8'd4, 32'hAAAA1000, 0, 1, 0, 0, 8'h44, 6'd4, 32'hAAAA1000};
    vt[5] = '{8'h45, 8'd4, 32'hAAAA1000, 4, 0, 0, 1, 8'h44, 6'd4, 32'hAAAA1000};
    vt[6] = '{8'h55, 8'd5, 32'h00000000, 3, 0, 0, 1, 8'h44, 6'd4, 32'hAAAA1000};
    vt[7] = '{8'hAA, 8'd4, 32'hAAAAAAAA, 0, 1, 0, 0, 8'hAA, 6'd4, 32'hAAAAAAAA};
    vt[8] = '{8'h66, 8'd1, 32'h7F000000, 2, 0, 0, 1, 8'hAA, 6'd4, 32'hAAAAAAAA};
    vt[9] = '{8'h01, 8'd4, 32'h00000000, 0, 1, 0, 0, 8'h01, 6'd4, 32'h00000000};

    rst = 1'b1;
    bus.i_en = 1'b1; bus.i_valid = 1'b0; bus.i_data = 8'h00;
    cclr = 1'b0; cupd = 1'b0; cdat = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst.frame", 64'(bus.o_frame), 64'd0);
    chk("rst.crc_err", 64'(bus.o_crc_err), 64'd0);
    chk("rst.frame_err", 64'(bus.o_frame_err), 64'd0);
    chk("rst.id", 64'(bus.o_id), 64'd0);
    chk("rst.len", 64'(bus.o_len), 64'd0);
    chk("rst.data", 64'(bus.o_data), 64'd0);

    s = "123456789";
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      cupd = 1'b1; cdat = s[i];
    end
    @(negedge clk);
    cupd = 1'b0;
    chk("crc32.check", 64'(cval ^ 32'hFFFFFFFF), 64'hCBF43926);

    for (int v = 0; v < 10; v++) begin
      f0 = n_frame; c0 = n_cerr; e0 = n_ferr;
      build(vt[v].id, vt[v].len, vt[v].pay, vt[v].mode);
      send(-1, txq.size());
      chk_frame($sformatf("vec%0d", v), vt[v].ef, vt[v].ec, vt[v].ee,
                f0, c0, e0, vt[v].eid, vt[v].elen, vt[v].edat);
    end

    f0 = n_frame; c0 = n_cerr; e0 = n_ferr;
    build(8'h5A, 8'd2, 32'hC3C40000, 0);
    send(6, txq.size());
    chk_frame("en_gap", 1, 0, 0, f0, c0, e0, 8'h5A, 6'd2, 32'hC3C40000);

    f0 = n_frame; c0 = n_cerr; e0 = n_ferr;
    build(8'h34, 8'd2, 32'h05060000, 0);
    txq.push_front(8'h02);
    txq.push_front(8'h01);
    txq.push_front(8'h04);
    txq.push_front(8'h12);
    repeat (3) txq.push_front(8'hAA);
    send(-1, txq.size());
    chk_frame("resync", 1, 0, 0, f0, c0, e0, 8'h34, 6'd2, 32'h05060000);

    build(8'h77, 8'd4, 32'h11223344, 0);
    send(-1, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.id", 64'(bus.o_id), 64'd0);
    chk("midrst.len", 64'(bus.o_len), 64'd0);
    chk("midrst.data", 64'(bus.o_data), 64'd0);
    f0 = n_frame; c0 = n_cerr; e0 = n_ferr;
    send(-1, txq.size());
    chk_frame("postrst", 1, 0, 0, f0, c0, e0, 8'h77, 6'd4, 32'h11223344);

    chk("onehot", 64'(multi), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/min_receive_fsm.md
# min_receive_fsm

Receive-side MIN framing decoder. It consumes the byte stream from the UART receiver on the sclk domain, removes byte stuffing and verifies the CRC-32. Each valid frame is presented as an ID, a length and a parallel payload bus, which is the mirror image of the transmit-side framing FSM. The host uses it to send configuration commands to the board, such as excitation phase step and CIC output select.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 4: largest accepted payload, in bytes (1..32).
- `LEN_WIDTH`, default 6: width of `o_len`; must satisfy 2^LEN_WIDTH > MAX_PAYLOAD.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`, in, 1: sampling clock (sclk).
- `i_rst`, in, 1: asynchronous active-high reset.
- `i_en`, in, 1: when low, input bytes are ignored and all state is held.
- `i_valid`, in, 1: one-cycle strobe; `i_data` holds a received byte.
- `i_data`, in, 8: received byte.
- `o_frame`, out, 1: one-cycle pulse; a good frame has been accepted.
- `o_id`, out, 8: ID/control byte of the last good frame.
- `o_len`, out, LEN_WIDTH: payload length of the last good frame.
- `o_data`, out, 8*MAX_PAYLOAD: payload. Byte 0 is in the MSBs; unused low bytes are zero.
- `o_crc_err`, out, 1: one-cycle pulse on CRC mismatch.
- `o_frame_err`, out, 1: one-cycle pulse on a framing error (bad stuff byte, missing EOF, or length > MAX_PAYLOAD).

## Operation
- Wire format: AA AA AA | ID | LEN | payload[LEN] | CRC[3..0] (big-endian) | 55.
- CRC-32 is reflected, polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. It is computed over ID, LEN and payload (unstuffed bytes).
- Stuffing applies to every byte after the SOF, up to and including the last CRC byte:
  - A counter tracks consecutive 0xAA bytes.
  - After two consecutive 0xAA, the next byte is handled as follows:
    - 0x55: discarded; counter cleared.
    - 0xAA: treated as a new SOF; the FSM goes to ID and clears the CRC and payload index.
    - Anything else: `o_frame_err` pulses and the FSM goes to SEARCH.
- States:
  - SEARCH: count consecutive 0xAA; on the third, go to ID.
  - ID: latch the ID and go to LEN.
  - LEN: if LEN > MAX_PAYLOAD, pulse `o_frame_err` and go to SEARCH. If LEN is 0, go to CRC. Otherwise go to PAYLOAD.
  - PAYLOAD: store each byte at the running index; after LEN bytes go to CRC.
  - CRC: shift in 4 bytes, then go to EOF.
  - EOF: if the byte is 0x55 and the CRC matches, pulse `o_frame` and update the outputs. If the byte is 0x55 but the CRC mismatches, pulse `o_crc_err`. If the byte is not 0x55, pulse `o_frame_err`. In every case return to SEARCH with the AA counter at 0.
- The EOF byte is never unstuffed.
- Payload is accumulated in an internal shadow buffer; `o_id`, `o_len` and `o_data` change only on a good frame. Failed frames leave them untouched.
- Bytes beyond LEN never write the buffer.
- Shadow-buffer bytes at or above LEN are zeroed when the frame starts.

## Timing
- Reset values: `o_frame`, `o_crc_err` and `o_frame_err` are 0. `o_id`, `o_len` and `o_data` are all zeros. State is SEARCH, AA counter 0, CRC 0xFFFFFFFF.
- Every output is registered.
- `o_frame` and the updated `o_id`, `o_len` and `o_data` appear in the cycle after the clock edge that samples the EOF byte (latency 1).
- At most one of `o_frame`, `o_crc_err` and `o_frame_err` is high in any cycle.
- The CRC updates one byte per cycle, combinationally from the registered CRC.
- Back-to-back `i_valid` on every cycle is supported.
- `i_valid` with `i_en` low is dropped entirely; nothing is counted and no CRC update occurs.
- Reset asserted mid-frame: the partial frame is discarded and the previous good outputs are cleared to zero.

## Structure
- Package `min_pkg`: constants SOF_BYTE = 8'hAA, STUFF_BYTE = 8'h55, EOF_BYTE = 8'h55, CRC_INIT, CRC_POLY and CRC_XOROUT; the state enum; function `crc32_byte(crc, byte)`.
- The package is shared with `min_transmit_fsm` in a later cleanup.
- Sub-module `min_crc32`: byte-wide CRC register with clear, update strobe and a 32-bit output. It is unit-tested separately.

## Test plan
- `min_crc32` fed ASCII "123456789" -> final complemented CRC = 0xCBF43926.
- Frame ID 0x80, LEN 4, payload 01 02 03 04, correct CRC from the bench model, EOF -> one `o_frame` pulse; `o_id` = 0x80, `o_len` = 4, `o_data` = 0x01020304.
- Payload AA AA 10 00 sent with the stuff byte after the second AA -> `o_data` = 0xAAAA1000 and `o_frame` pulses. The same frame sent without the stuff byte -> `o_frame_err` pulses and the outputs are unchanged.
- Good frame with one CRC byte flipped -> `o_crc_err` pulses; the outputs still hold the previous frame.
- LEN = 5 with MAX_PAYLOAD = 4 -> `o_frame_err` after the LEN byte. The following valid frame is then accepted normally.
- Mid-payload AA AA AA and then a complete new frame -> resync, and only the new frame is reported. Separately, `i_rst` pulsed mid-frame -> all outputs are 0 and the next frame decodes correctly.
